// File: rtl/ser_sched.sv
// Round-robin scheduler feeding one MSB-first byte serialiser; bit 7 appears 1 cycle after accept.
// Backpressure: req_ready is a combinational one-hot grant, only at accept opportunities.
module ser_sched #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic                 t_clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3:0]           cfg_gap,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 ser_sof,
  output logic                 ser_eof,
  output logic [SRC_W-1:0]     ser_src,
  output logic                 busy,
  output logic [15:0]          tx_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         bit_cnt_q;
  logic [3:0]         gap_q;
  logic [3:0]         gap_cnt_q;
  logic [7:0]         shift_q;
  logic [SRC_W-1:0]   rr_ptr_q;
  logic [SRC_W-1:0]   rr_ptr_nxt;

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 win_vld;
  logic [SRC_W-1:0]     win_idx;
  logic [SRC_W:0]       win_sum;
  logic [7:0]           win_byte;
  logic                 opp;
  logic                 accept;

  // Rotate the request vector so bit 0 is the source at rr_ptr.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = NUM_REQ'(valid_dbl >> rr_ptr_q);

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && valid_rot[i]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
        if (win_sum >= (SRC_W+1)'(NUM_REQ)) begin
          win_sum = win_sum - (SRC_W+1)'(NUM_REQ);
        end
        win_idx = win_sum[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_idx == SRC_W'(j)) begin
        win_byte = req_data[8*j +: 8];
      end
    end
  end

  assign opp = rst_n &&
               ((state_q == IDLE) ||
                (state_q == SHIFT && bit_cnt_q == 3'd7 && gap_q == 4'd0) ||
                (state_q == GAP && gap_cnt_q == 4'd0));
  assign accept = opp && win_vld;

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = accept && (win_idx == SRC_W'(j));
    end
  end

  assign rr_ptr_nxt = (win_idx == SRC_W'(NUM_REQ-1)) ? '0 : win_idx + SRC_W'(1);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = SHIFT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        SHIFT:   if (bit_cnt_q == 3'd7) state_d = (gap_q != 4'd0) ? GAP : IDLE;
        GAP:     if (gap_cnt_q == 4'd0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge t_clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge t_clk) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      shift_q   <= '0;
      rr_ptr_q  <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_sof   <= 1'b0;
      ser_eof   <= 1'b0;
      ser_src   <= '0;
      tx_count  <= '0;
    end else if (accept) begin
      shift_q   <= {win_byte[6:0], 1'b0};
      ser_out   <= win_byte[7];
      ser_valid <= 1'b1;
      ser_sof   <= 1'b1;
      ser_eof   <= 1'b0;
      bit_cnt_q <= '0;
      ser_src   <= win_idx;
      rr_ptr_q  <= rr_ptr_nxt;
      gap_q     <= cfg_gap;
      tx_count  <= tx_count + 16'd1;
    end else if (state_q == SHIFT && bit_cnt_q != 3'd7) begin
      shift_q   <= {shift_q[6:0], 1'b0};
      ser_out   <= shift_q[7];
      ser_sof   <= 1'b0;
      ser_eof   <= (bit_cnt_q == 3'd6);
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end else begin
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_sof   <= 1'b0;
      ser_eof   <= 1'b0;
      // Gap counter runs G-1 down to 0 so its zero cycle is the next opportunity.
      if (state_q == SHIFT && gap_q != 4'd0) begin
        gap_cnt_q <= gap_q - 4'd1;
      end else if (state_q == GAP && gap_cnt_q != 4'd0) begin
        gap_cnt_q <= gap_cnt_q - 4'd1;
      end
    end
  end

endmodule
